// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction fields, supports stall (freeze),
// branch kill (flush) and counts the bubbles inserted by flushes.
module id_stage_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          freeze,
  input  logic          valid_in,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] val_rn_in,
  input  logic [DW-1:0] val_rm_in,
  input  logic          imm_in,
  input  logic [11:0]   shift_operand_in,
  input  logic [23:0]   signed_imm24_in,
  input  logic [3:0]    dest_in,
  input  logic [3:0]    src1_in,
  input  logic [3:0]    src2_in,
  input  logic [3:0]    exe_cmd_in,
  input  logic          wb_en_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic          b_in,
  input  logic          s_in,
  input  logic [3:0]    status_in,
  output logic          valid_out,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] val_rn_out,
  output logic [DW-1:0] val_rm_out,
  output logic          imm_out,
  output logic [11:0]   shift_operand_out,
  output logic [23:0]   signed_imm24_out,
  output logic [3:0]    dest_out,
  output logic [3:0]    src1_out,
  output logic [3:0]    src2_out,
  output logic [3:0]    exe_cmd_out,
  output logic          wb_en_out,
  output logic          mem_r_en_out,
  output logic          mem_w_en_out,
  output logic          b_out,
  output logic          s_out,
  output logic [3:0]    status_out,
  output logic          val2_sel_out,
  output logic [7:0]    bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic          imm;
    logic [11:0]   shift_operand;
    logic [23:0]   signed_imm24;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic [3:0]    exe_cmd;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          b;
    logic          s;
    logic [3:0]    status;
    logic          val2_sel;
  } slot_t;

  slot_t      slot_q, slot_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns slot_d/cnt_d and no latch is inferred.
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (flush) begin
      slot_d = '0;
      if (valid_in && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end else if (!freeze) begin
      slot_d.valid         = valid_in;
      slot_d.pc            = pc_in;
      slot_d.val_rn        = val_rn_in;
      slot_d.val_rm        = val_rm_in;
      slot_d.imm           = imm_in;
      slot_d.shift_operand = shift_operand_in;
      slot_d.signed_imm24  = signed_imm24_in;
      slot_d.dest          = dest_in;
      slot_d.src1          = src1_in;
      slot_d.src2          = src2_in;
      slot_d.exe_cmd       = exe_cmd_in;
      slot_d.wb_en         = wb_en_in;
      slot_d.mem_r_en      = mem_r_en_in;
      slot_d.mem_w_en      = mem_w_en_in;
      slot_d.b             = b_in;
      slot_d.s             = s_in;
      slot_d.status        = status_in;
      slot_d.val2_sel      = mem_r_en_in | mem_w_en_in;
      // An invalid slot must never write back, touch memory or branch.
      if (!valid_in) begin
        slot_d.wb_en    = 1'b0;
        slot_d.mem_r_en = 1'b0;
        slot_d.mem_w_en = 1'b0;
        slot_d.b        = 1'b0;
        slot_d.s        = 1'b0;
        slot_d.val2_sel = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_out         = slot_q.valid;
  assign pc_out            = slot_q.pc;
  assign val_rn_out        = slot_q.val_rn;
  assign val_rm_out        = slot_q.val_rm;
  assign imm_out           = slot_q.imm;
  assign shift_operand_out = slot_q.shift_operand;
  assign signed_imm24_out  = slot_q.signed_imm24;
  assign dest_out          = slot_q.dest;
  assign src1_out          = slot_q.src1;
  assign src2_out          = slot_q.src2;
  assign exe_cmd_out       = slot_q.exe_cmd;
  assign wb_en_out         = slot_q.wb_en;
  assign mem_r_en_out      = slot_q.mem_r_en;
  assign mem_w_en_out      = slot_q.mem_w_en;
  assign b_out             = slot_q.b;
  assign s_out             = slot_q.s;
  assign status_out        = slot_q.status;
  assign val2_sel_out      = slot_q.val2_sel;
  assign bubble_cnt        = cnt_q;

endmodule

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the width of the PC and register-operand datapath.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  branch-taken kill: next captured slot becomes a bubble.
REQ-005 SHALL have port freeze  input  1  hazard stall: hold all registered outputs.
REQ-006 SHALL have port valid_in  input  1  ID stage presents a real instruction.
REQ-007 SHALL have port pc_in  input  DW  PC+4 of the ID instruction.
REQ-008 SHALL have ports val_rn_in, val_rm_in  input  DW each  register-file read data.
REQ-009 SHALL have ports imm_in  input  1 and shift_operand_in  input  12  operand-2 encoding fields.
REQ-010 SHALL have port signed_imm24_in  input  24  branch offset.
REQ-011 SHALL have ports dest_in, src1_in, src2_in  input  4 each  destination and source register numbers.
REQ-012 SHALL have port exe_cmd_in  input  4  ALU command.
REQ-013 SHALL have ports wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  input  1 each  control bits.
REQ-014 SHALL have port status_in  input  4  NZCV flags sampled with the instruction.
REQ-015 SHALL have a registered output of identical width named *_out for every input in REQ-006..REQ-014, plus val2_sel_out  output  1  (mem_r_en|mem_w_en), the operand-2 mode select for the EXE operand generator.
REQ-016 SHALL have port bubble_cnt  output  8  count of bubbles inserted by flush since reset, saturating.

Function
REQ-017 SHALL, on a rising clk edge with freeze=0 and flush=0, capture every *_in into the matching *_out and set val2_sel_out = mem_r_en_in|mem_w_en_in.
REQ-018 SHALL, on a rising edge with flush=1, load a bubble: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, val2_sel_out = 0; exe_cmd_out = 0; dest_out/src1_out/src2_out = 0; datapath fields = 0.
REQ-019 SHALL give flush priority over freeze: flush=1 and freeze=1 in the same cycle loads a bubble.
REQ-020 SHALL, on a rising edge with freeze=1 and flush=0, hold every output unchanged, including bubble_cnt.
REQ-021 SHALL treat valid_in=0 as a bubble: control bits captured as 0 regardless of their input values; datapath fields captured as presented.
REQ-022 SHALL increment bubble_cnt by 1 on each edge that loads a bubble via flush while valid_in=1; saturate at 255, no wrap.
REQ-023 SHALL have latency exactly one cycle from input to output when not frozen; no combinational path from any input to any output.
REQ-024 SHALL keep src1_out/src2_out meaningful only when valid_out=1; forwarding logic downstream ignores them otherwise.
REQ-025 SHALL present outputs that are functions of register state only (Moore), stable for the whole cycle.

Reset
REQ-026 SHALL, while rst_n=0, force asynchronously every output including bubble_cnt to 0, independent of clk.
REQ-027 SHALL, on rst_n rising, take no action until the next rising clk edge; first edge follows REQ-017..REQ-022.
REQ-028 SHALL discard any in-flight instruction when reset asserts mid-operation; frozen contents are not retained.

Verification
REQ-029 Capture: valid_in=1, pc_in=0x104, val_rm_in=0x8000_0001, imm_in=0, shift_operand_in=0x0E3, mem_r_en_in=1, one edge -> all outputs mirror inputs, val2_sel_out=1, valid_out=1.
REQ-030 Freeze: load instruction A, then freeze=1 for 3 edges with instruction B on inputs -> outputs remain A for all 3 cycles; freeze=0 -> B appears after next edge.
REQ-031 Flush over freeze: flush=1, freeze=1, valid_in=1, wb_en_in=1 -> after edge valid_out=0, wb_en_out=0, exe_cmd_out=0, bubble_cnt=1.
REQ-032 Saturation: 260 consecutive flush edges with valid_in=1 -> bubble_cnt=255 and stays 255.
REQ-033 Async reset: assert rst_n=0 mid-cycle between edges with valid_out=1 -> all outputs 0 immediately, no clk edge required; release -> first edge captures normally.
REQ-034 Invalid input: valid_in=0, wb_en_in=1, mem_w_en_in=1 -> after edge wb_en_out=0, mem_w_en_out=0, val2_sel_out=0, bubble_cnt unchanged.
